// File: rtl/sm_binary_to_bcd.sv
// Sequential sign-magnitude binary to signed BCD converter.
// Uses shift-and-add-3 (double dabble), one magnitude bit per clock, with a
// start/busy/done handshake. Output format: [15] sign, [14:12] zero,
// [11:8] hundreds, [7:4] tens, [3:0] ones.
module sm_binary_to_bcd #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] binary_sm,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd
);

    localparam int M  = N - 1;        // magnitude width
    localparam int CW = $clog2(N);    // counter must hold N-1

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    mag_q,   mag_d;
    logic [11:0]     scr_q,   scr_d;
    logic            sign_q,  sign_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [15:0]     bcd_q,   bcd_d;

    logic [11:0]     scr_adj;
    logic            accept;

    // Add-3 correction applied to each scratch digit before it is doubled
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign scr_adj[gi*4 +: 4] = (scr_q[gi*4 +: 4] >= 4'd5)
                                      ? scr_q[gi*4 +: 4] + 4'd3
                                      : scr_q[gi*4 +: 4];
        end
    endgenerate

    // A new operand may be taken when idle or in the final (result) cycle
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state and datapath logic; all outputs come from registers
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
            end
            SHIFT: begin
                busy_d = 1'b1;
                scr_d  = {scr_adj[10:0], mag_q[M-1]};
                mag_d  = {mag_q[M-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Negative zero is reported as positive zero
                bcd_d   = {sign_q & (|scr_q), 3'b000, scr_q};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) begin
            mag_d   = binary_sm[M-1:0];
            sign_d  = binary_sm[N-1];
            scr_d   = 12'h000;
            cnt_d   = CW'(N - 1);
            busy_d  = 1'b1;
            state_d = SHIFT;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            scr_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_sm_binary_to_bcd.sv
// Directed and exhaustive bench for sm_binary_to_bcd at N=8 and N=10.
module tb_sm_binary_to_bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  bin8 = 8'h00;
    logic        busy8, done8;
    logic [15:0] bcd8;

    logic        start10 = 1'b0;
    logic [9:0]  bin10 = 10'h000;
    logic        busy10, done10;
    logic [15:0] bcd10;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sm_binary_to_bcd #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .binary_sm(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8)
    );

    sm_binary_to_bcd #(.N(10)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .binary_sm(bin10),
        .busy(busy10), .done(done10), .bcd(bcd10)
    );

    // Reference: sign/hundreds/tens/ones of the magnitude, -0 -> +0
    function automatic logic [15:0] model(input int n, input int v);
        int mag;
        int s;
        mag = v & ((1 << (n - 1)) - 1);
        s   = (v >> (n - 1)) & 1;
        if (mag == 0) return 16'h0000;
        return {s[0], 3'b000, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    // Accept one operand on the N=8 unit and wait (bounded) for done
    task automatic conv8(input logic [7:0] v, output int lat, output logic [15:0] res,
                         output logic busy_acc);
        start8 = 1'b1;
        bin8   = v;
        @(posedge clk); #1;
        start8   = 1'b0;
        busy_acc = busy8;
        lat = -1;
        res = 16'hxxxx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = c;
                res = bcd8;
                break;
            end
        end
    endtask

    task automatic conv10(input logic [9:0] v, output int lat, output logic [15:0] res);
        start10 = 1'b1;
        bin10   = v;
        @(posedge clk); #1;
        start10 = 1'b0;
        lat = -1;
        res = 16'hxxxx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done10) begin
                lat = c;
                res = bcd10;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start8 = 1'b1;
        bin8   = 8'h7F;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d busy=%b done=%b bcd=%h want 0/0/0000", i, busy8, done8, bcd8);
            end
        end
        reset  = 1'b0;
        start8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_release busy=%b done=%b bcd=%h want 0/0/0000", busy8, done8, bcd8);
        end
        $display("reset: busy=%b done=%b bcd=%h", busy8, done8, bcd8);
    endtask

    task automatic test_basic();
        logic [7:0]  ops [6];
        logic [15:0] exp [6];
        int          lat;
        logic [15:0] res;
        logic        bacc;
        ops[0] = 8'h7F; exp[0] = 16'h0127;
        ops[1] = 8'hFF; exp[1] = 16'h8127;
        ops[2] = 8'h2A; exp[2] = 16'h0042;
        ops[3] = 8'h85; exp[3] = 16'h8005;
        ops[4] = 8'h00; exp[4] = 16'h0000;
        ops[5] = 8'h80; exp[5] = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            conv8(ops[i], lat, res, bacc);
            total++;
            if (bacc !== 1'b1) begin
                bad++;
                $display("FAIL basic_busy op=%h busy=%b want 1", ops[i], bacc);
            end
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL basic_latency op=%h got=%0d want 8", ops[i], lat);
            end
            total++;
            if (res !== exp[i]) begin
                bad++;
                $display("FAIL basic_value op=%h got=%h want %h", ops[i], res, exp[i]);
            end
            total++;
            if (busy8 !== 1'b0) begin
                bad++;
                $display("FAIL basic_busy_done op=%h busy=%b want 0", ops[i], busy8);
            end
            @(posedge clk); #1;
            total++;
            if (done8 !== 1'b0 || bcd8 !== exp[i]) begin
                bad++;
                $display("FAIL basic_pulse op=%h done=%b bcd=%h want 0/%h", ops[i], done8, bcd8, exp[i]);
            end
            $display("basic: op=%h bcd=%h latency=%0d", ops[i], res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int          d1 = -1;
        int          d2 = -1;
        int          ndone = 0;
        logic        busy_drop = 1'b0;
        logic [15:0] r1 = 16'h0;
        logic [15:0] r2 = 16'h0;
        start8 = 1'b1;
        bin8   = 8'h63;
        @(posedge clk); #1;
        bin8 = 8'hE4;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = c; r1 = bcd8;
                    start8 = 1'b0;
                end else if (d2 < 0) begin
                    d2 = c; r2 = bcd8;
                end
            end
            if (d2 < 0 && busy8 !== 1'b1) busy_drop = 1'b1;
        end
        start8 = 1'b0;
        total++;
        if (d1 !== 8 || r1 !== 16'h0099) begin
            bad++;
            $display("FAIL b2b_first at=%0d bcd=%h want 8/0099", d1, r1);
        end
        total++;
        if (d2 !== 16 || r2 !== 16'h8100) begin
            bad++;
            $display("FAIL b2b_second at=%0d bcd=%h want 16/8100", d2, r2);
        end
        total++;
        if (busy_drop !== 1'b0 || ndone !== 2) begin
            bad++;
            $display("FAIL b2b_busy busy_dropped=%b dones=%0d want 0/2", busy_drop, ndone);
        end
        $display("back_to_back: done at %0d (%h) and %0d (%h)", d1, r1, d2, r2);
    endtask

    task automatic test_ignore_busy();
        int          ndone = 0;
        int          at = -1;
        logic [15:0] r = 16'h0;
        start8 = 1'b1;
        bin8   = 8'h0C;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bin8 = 8'(c * 37 + 5);
            if (c == 3) begin
                start8 = 1'b1;
                bin8   = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                at = c;
                r  = bcd8;
            end
        end
        start8 = 1'b0;
        bin8   = 8'h00;
        total++;
        if (ndone !== 1 || at !== 8 || r !== 16'h0012) begin
            bad++;
            $display("FAIL ignore_busy dones=%0d at=%0d bcd=%h want 1/8/0012", ndone, at, r);
        end
        $display("ignore_busy: dones=%0d bcd=%h", ndone, r);
    endtask

    task automatic test_reset_mid();
        int          ndone = 0;
        logic        bcd_bad = 1'b0;
        int          lat;
        logic [15:0] res;
        logic        bacc;
        start8 = 1'b1;
        bin8   = 8'h7F;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            reset = (c == 4);
            @(posedge clk); #1;
            if (done8) ndone++;
            if (c >= 4 && bcd8 !== 16'h0000) bcd_bad = 1'b1;
        end
        reset = 1'b0;
        total++;
        if (ndone !== 0 || bcd_bad !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid dones=%0d bcd_changed=%b want 0/0", ndone, bcd_bad);
        end
        conv8(8'h01, lat, res, bacc);
        total++;
        if (lat !== 8 || res !== 16'h0001) begin
            bad++;
            $display("FAIL reset_mid_next lat=%0d bcd=%h want 8/0001", lat, res);
        end
        $display("reset_mid: dones=%0d then bcd=%h", ndone, res);
    endtask

    task automatic test_exhaustive();
        int          lat;
        logic [15:0] res;
        logic [15:0] exp;
        logic        bacc;
        int          errs8 = 0;
        int          errs10 = 0;
        for (int v = 0; v < 256; v++) begin
            conv8(8'(v), lat, res, bacc);
            exp = model(8, v);
            total++;
            if (lat !== 8 || res !== exp) begin
                bad++;
                errs8++;
                $display("FAIL exh8 op=%h lat=%0d bcd=%h want 8/%h", v[7:0], lat, res, exp);
            end
        end
        $display("exhaustive N=8: 256 operands, %0d wrong", errs8);
        for (int v = 0; v < 1024; v++) begin
            conv10(10'(v), lat, res);
            exp = model(10, v);
            total++;
            if (lat !== 10 || res !== exp) begin
                bad++;
                errs10++;
                $display("FAIL exh10 op=%h lat=%0d bcd=%h want 10/%h", v[9:0], lat, res, exp);
            end
        end
        $display("exhaustive N=10: 1024 operands, %0d wrong", errs10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_ignore_busy();
        test_reset_mid();
        @(posedge clk); #1;
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
